// File: rtl/div_if.sv
// Handshake/operand bundle between the EX stage and the iterative divider.
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );
endinterface

// File: rtl/div.sv
// Iterative 32-bit restoring divider, result {rem, quo}.
// Optional DIV_ZERO_DETECT_EN: zero divisor finishes early with result 0.
module div (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ON     = 2'd1,
    END    = 2'd2
`ifdef DIV_ZERO_DETECT_EN
    , BYZERO = 2'd3
`endif
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [5:0]  r_cnt;
  logic [64:0] r_work;
  logic [31:0] r_dvs;
  logic        r_sgn;
  logic        r_s1;
  logic        r_s2;
  logic [63:0] r_result;
  logic        r_ready;

  logic        w_go;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_diff;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_go = bus.start_i && !bus.annul_i;

  assign w_abs1 = (bus.signed_div_i && bus.opdata1_i[31]) ?
                  (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign w_abs2 = (bus.signed_div_i && bus.opdata2_i[31]) ?
                  (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

  assign w_diff = {1'b0, r_work[63:32]} - {1'b0, r_dvs};

  // Sign fix-up on the final unsigned quotient/remainder
  assign w_quo = (r_sgn && (r_s1 ^ r_s2)) ?
                 (~r_work[31:0] + 32'd1) : r_work[31:0];
  assign w_rem = (r_sgn && r_s1) ?
                 (~r_work[64:33] + 32'd1) : r_work[64:33];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= FREE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      FREE: begin
        if (w_go) begin
`ifdef DIV_ZERO_DETECT_EN
          w_nxt = (bus.opdata2_i == 32'd0) ? BYZERO : ON;
`else
          w_nxt = ON;
`endif
        end
      end
`ifdef DIV_ZERO_DETECT_EN
      BYZERO: begin
        w_nxt = bus.annul_i ? FREE : END;
      end
`endif
      ON: begin
        if (bus.annul_i)          w_nxt = FREE;
        else if (r_cnt == 6'd32)  w_nxt = END;
      end
      END: begin
        if (!bus.start_i) w_nxt = FREE;
      end
      default: w_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= 6'd0;
      r_work   <= 65'd0;
      r_dvs    <= 32'd0;
      r_sgn    <= 1'b0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_result <= 64'd0;
      r_ready  <= 1'b0;
    end else begin
      unique case (r_state)
        FREE: begin
          if (w_go) begin
            r_cnt  <= 6'd0;
            r_work <= {32'd0, w_abs1, 1'b0};
            r_dvs  <= w_abs2;
            r_sgn  <= bus.signed_div_i;
            r_s1   <= bus.opdata1_i[31];
            r_s2   <= bus.opdata2_i[31];
          end
        end
`ifdef DIV_ZERO_DETECT_EN
        BYZERO: begin
          if (!bus.annul_i) begin
            r_result <= 64'd0;
            r_ready  <= 1'b1;
          end
        end
`endif
        ON: begin
          if (bus.annul_i) begin
            r_cnt <= 6'd0;
          end else if (r_cnt != 6'd32) begin
            if (w_diff[32])
              r_work <= {r_work[63:0], 1'b0};
            else
              r_work <= {w_diff[31:0], r_work[31:0], 1'b1};
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_result <= {w_rem, w_quo};
            r_ready  <= 1'b1;
            r_cnt    <= 6'd0;
          end
        end
        END: begin
          if (!bus.start_i) begin
            r_result <= 64'd0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: vector table plus annul/reset sequences.
module tb_div;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_if bus ();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t        vt[$];
  logic [63:0] sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [63:0] model(input logic sgn,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sd, q, r;
    logic [31:0] uq, ur;
    if (sgn) begin
      sa = a;
      sd = b;
      q  = sa / sd;
      r  = sa % sd;
      return {r, q};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic run_div(input logic sgn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [63:0] exp,
                         input string nm);
    int          lat;
    int          explat;
    logic        busy_ok;
    logic [63:0] want;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~sgn;
    lat     = 0;
    busy_ok = 1'b1;
    while (lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.ready_o) break;
      if (bus.result_o != 64'd0) busy_ok = 1'b0;
    end
`ifdef DIV_ZERO_DETECT_EN
    explat = (b == 32'd0) ? 1 : 33;
`else
    explat = 33;
`endif
    chk({nm, "_lat"}, 64'(lat), 64'(explat));
    chk({nm, "_busy0"}, {63'd0, busy_ok}, 64'd1);
    want = sb.pop_front();
    chk(nm, bus.result_o, want);
    @(posedge clk);
    #1;
    chk({nm, "_hold"}, {bus.ready_o, bus.result_o[62:0]},
        {1'b1, want[62:0]});
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_drop"}, {bus.ready_o, bus.result_o[62:0]}, 64'd0);
  endtask

  task automatic watch_idle(input string nm);
    logic saw;
    saw = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (bus.ready_o || bus.result_o != 64'd0) saw = 1'b1;
    end
    chk(nm, {63'd0, saw}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    vec_t        v;

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    vt.push_back('{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}});
    vt.push_back('{1'b1, 32'hFFFFFFF9, 32'd2,
                   {32'hFFFFFFFF, 32'hFFFFFFFD}});
    vt.push_back('{1'b1, 32'd7, 32'hFFFFFFFE,
                   {32'h00000001, 32'hFFFFFFFD}});
    vt.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF,
                   {32'd0, 32'h80000000}});
    vt.push_back('{1'b0, 32'hFFFFFFFF, 32'd1,
                   {32'd0, 32'hFFFFFFFF}});
`ifdef DIV_ZERO_DETECT_EN
    vt.push_back('{1'b0, 32'd5, 32'd0, 64'd0});
`else
    vt.push_back('{1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}});
`endif
    vt.push_back('{1'b0, 32'd3, 32'd10, {32'd3, 32'd0}});

    for (int i = 0; i < 6; i++) begin
      rs = i[0];
      ra = $urandom;
      rb = $urandom >> (i * 5);
      if (rb == 32'd0) rb = 32'd13;
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      vt.push_back('{rs, ra, rb, model(rs, ra, rb)});
    end

    foreach (vt[i]) begin
      v = vt[i];
      run_div(v.sgn, v.a, v.b, v.exp, $sformatf("vec%0d", i));
    end

    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_now", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    watch_idle("annul_never");
    run_div(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, "after_annul");

    @(negedge clk);
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFFFC18;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid", {bus.ready_o, bus.result_o[62:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    watch_idle("rst_idle");
    run_div(1'b1, 32'hFFFFFC18, 32'd7,
            model(1'b1, 32'hFFFFFC18, 32'd7), "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
